// File: rtl/result_checker.sv
// result_checker: compares each valid CPU Result sample against a programmable
// masked expected-value table; counts mismatches, captures the first one, and times out.
`default_nettype none

module result_checker #(
   parameter  int DATA_W  = 32,
   parameter  int DEPTH   = 16,
   parameter  int TIMEOUT = 1024,
   parameter  int ERR_W   = 16,
   localparam int IDX_W   = $clog2(DEPTH),
   localparam int NUM_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [DATA_W-1:0] exp_mask,
   input  logic [NUM_W-1:0]  num_exp,
   input  logic              start,
   input  logic [DATA_W-1:0] Result,
   input  logic              result_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timed_out,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_got,
   output logic [NUM_W-1:0]  sample_idx
);

   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [DATA_W-1:0]   r_exp_data [DEPTH];
   logic [DATA_W-1:0]   r_exp_mask [DEPTH];
   logic [NUM_W-1:0]    r_num;
   logic [NUM_W-1:0]    r_sample_idx;
   logic [ERR_W-1:0]    r_err_cnt;
   logic [IDX_W-1:0]    r_first_idx;
   logic [DATA_W-1:0]   r_first_got;
   logic                r_first_valid;
   logic [WD_W-1:0]     r_wd;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic                r_to;

   logic [IDX_W-1:0]    w_idx;
   logic                w_mismatch;
   logic [ERR_W-1:0]    w_err_next;
   logic [NUM_W-1:0]    w_num_clamp;
   logic                w_last;

   // Table storage is deliberately not reset so a test program survives a reset.
   always_ff @(posedge clk) begin
      if (exp_we && r_state != S_RUN) begin
         r_exp_data[exp_addr] <= exp_data;
         r_exp_mask[exp_addr] <= exp_mask;
      end
   end

   assign w_idx       = r_sample_idx[IDX_W-1:0];
   assign w_mismatch  = |((Result ^ r_exp_data[w_idx]) & r_exp_mask[w_idx]);
   assign w_err_next  = (w_mismatch && r_err_cnt != '1) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
   assign w_num_clamp = (num_exp > NUM_W'(DEPTH)) ? NUM_W'(DEPTH) : num_exp;
   assign w_last      = (r_sample_idx == r_num - NUM_W'(1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN: begin
            if (result_valid) begin
               if (w_last)
                  w_next = (w_err_next == '0) ? S_PASS : S_FAIL;
            end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
               w_next = S_TIMEOUT;
            end
         end
         default: begin
            if (start)
               w_next = (w_num_clamp == '0) ? S_PASS : S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_num         <= '0;
         r_sample_idx  <= '0;
         r_err_cnt     <= '0;
         r_first_idx   <= '0;
         r_first_got   <= '0;
         r_first_valid <= 1'b0;
         r_wd          <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pass        <= 1'b0;
         r_to          <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == S_RUN);
         r_done  <= (w_next == S_PASS) || (w_next == S_FAIL) || (w_next == S_TIMEOUT);
         r_pass  <= (w_next == S_PASS);
         r_to    <= (w_next == S_TIMEOUT);
         if (r_state == S_RUN) begin
            if (result_valid) begin
               r_err_cnt    <= w_err_next;
               r_sample_idx <= r_sample_idx + NUM_W'(1);
               r_wd         <= '0;
               if (w_mismatch && !r_first_valid) begin
                  r_first_idx   <= w_idx;
                  r_first_got   <= Result;
                  r_first_valid <= 1'b1;
               end
            end else begin
               r_wd <= r_wd + WD_W'(1);
            end
         end else if (start) begin
            r_num         <= w_num_clamp;
            r_sample_idx  <= '0;
            r_err_cnt     <= '0;
            r_first_idx   <= '0;
            r_first_got   <= '0;
            r_first_valid <= 1'b0;
            r_wd          <= '0;
         end
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign timed_out     = r_to;
   assign err_cnt       = r_err_cnt;
   assign first_err_idx = r_first_idx;
   assign first_err_got = r_first_got;
   assign sample_idx    = r_sample_idx;

endmodule

`default_nettype wire

// File: tb/tb_result_checker.sv
// tb_result_checker: randomized self-checking bench for result_checker against a table-based reference model.
`default_nettype none

module tb_result_checker;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 8;
   localparam int ERR_W   = 3;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int NUM_W   = $clog2(DEPTH + 1);
   localparam int SAT     = (1 << ERR_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              exp_we;
   logic [IDX_W-1:0]  exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic [DATA_W-1:0] exp_mask;
   logic [NUM_W-1:0]  num_exp;
   logic              start;
   logic [DATA_W-1:0] Result;
   logic              result_valid;
   logic              busy, done, pass, timed_out;
   logic [ERR_W-1:0]  err_cnt;
   logic [IDX_W-1:0]  first_err_idx;
   logic [DATA_W-1:0] first_err_got;
   logic [NUM_W-1:0]  sample_idx;

   result_checker #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .TIMEOUT(TIMEOUT),
      .ERR_W  (ERR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .exp_we       (exp_we),
      .exp_addr     (exp_addr),
      .exp_data     (exp_data),
      .exp_mask     (exp_mask),
      .num_exp      (num_exp),
      .start        (start),
      .Result       (Result),
      .result_valid (result_valid),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .timed_out    (timed_out),
      .err_cnt      (err_cnt),
      .first_err_idx(first_err_idx),
      .first_err_got(first_err_got),
      .sample_idx   (sample_idx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [DATA_W-1:0] m_exp  [DEPTH];
   logic [DATA_W-1:0] m_mask [DEPTH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m, input bit model);
      exp_we   = 1'b1;
      exp_addr = a[IDX_W-1:0];
      exp_data = d;
      exp_mask = m;
      tick;
      exp_we = 1'b0;
      if (model) begin
         m_exp[a]  = d;
         m_mask[a] = m;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_to"}, timed_out, 0);
      chk({tag, "_err"}, err_cnt, 0);
      chk({tag, "_fidx"}, first_err_idx, 0);
      chk({tag, "_fgot"}, first_err_got, 0);
      chk({tag, "_sidx"}, sample_idx, 0);
   endtask

   // Full run: model counts masked mismatches over the clamped sample list.
   task automatic run(input int n, input logic [DATA_W-1:0] s[$]);
      int nc;
      int cnt;
      int first;
      logic [DATA_W-1:0] fgot;
      nc    = (n > DEPTH) ? DEPTH : n;
      cnt   = 0;
      first = -1;
      fgot  = '0;
      start   = 1'b1;
      num_exp = n[NUM_W-1:0];
      tick;
      start  = 1'b0;
      exp_we = 1'b0;
      if (nc == 0) begin
         chk("zero_pass", pass, 1);
         chk("zero_done", done, 1);
         chk("zero_busy", busy, 0);
         return;
      end
      chk("start_busy", busy, 1);
      chk("start_err", err_cnt, 0);
      chk("start_sidx", sample_idx, 0);
      for (int i = 0; i < nc; i++) begin
         repeat ($urandom_range(0, 3)) begin
            Result = $urandom;
            tick;
         end
         Result       = s[i];
         result_valid = 1'b1;
         tick;
         result_valid = 1'b0;
         Result       = $urandom;
         if (((s[i] ^ m_exp[i]) & m_mask[i]) != 0) begin
            cnt++;
            if (first < 0) begin
               first = i;
               fgot  = s[i];
            end
         end
         chk("sample_idx", sample_idx, i + 1);
         chk("err_cnt", err_cnt, (cnt > SAT) ? SAT : cnt);
         chk("busy", busy, (i < nc - 1));
      end
      chk("done", done, 1);
      chk("pass", pass, (cnt == 0));
      chk("timed_out", timed_out, 0);
      chk("first_idx", first_err_idx, (first < 0) ? 0 : first);
      chk("first_got", first_err_got, fgot);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [DATA_W-1:0] q[$];
      int n;
      rst = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_mask = '0;
      num_exp = '0; start = 1'b0; Result = '0; result_valid = 1'b0;
      #20;
      chk_all_zero("reset");
      rst = 1'b1;
      tick;

      // Pass run with a fixed table.
      wr(0, 5, '1, 1); wr(1, 10, '1, 1); wr(2, 15, '1, 1); wr(3, 20, '1, 1);
      q = '{5, 10, 15, 20};
      run(4, q);
      chk("pass_run_pass", pass, 1);

      // Fail run.
      q = '{5, 11, 15, 99};
      run(4, q);
      chk("fail_run_err", err_cnt, 2);
      chk("fail_run_fidx", first_err_idx, 1);
      chk("fail_run_fgot", first_err_got, 11);

      // Masked compare.
      wr(0, 32'h1234_5600, 32'hFFFF_FF00, 1);
      q = '{32'h1234_56AB};
      run(1, q);
      chk("mask_pass", pass, 1);

      // Zero count.
      q = {};
      run(0, q);

      // Timeout after one sample; a RUN-time write must be ignored.
      start = 1'b1; num_exp = 2; tick; start = 1'b0;
      Result = 32'h1234_5600; result_valid = 1'b1; tick; result_valid = 1'b0;
      wr(1, 32'hDEAD_BEEF, '1, 0);
      repeat (6) tick;
      chk("to_not_yet", timed_out, 0);
      chk("to_busy", busy, 1);
      tick;
      chk("to_hit", timed_out, 1);
      chk("to_done", done, 1);
      chk("to_pass", pass, 0);
      chk("to_busy_low", busy, 0);
      q = '{m_exp[0], m_exp[1]};
      run(2, q);
      chk("we_in_run_ignored", pass, 1);

      // Timeout measured from busy rising, no samples at all.
      start = 1'b1; num_exp = 3; tick; start = 1'b0;
      chk("to2_busy", busy, 1);
      repeat (7) tick;
      chk("to2_not_yet", timed_out, 0);
      tick;
      chk("to2_hit", timed_out, 1);

      // Simultaneous start and table write.
      exp_we = 1'b1; exp_addr = 0; exp_data = 77; exp_mask = '1;
      m_exp[0] = 77; m_mask[0] = '1;
      q = '{77};
      run(1, q);

      // Error counter saturation.
      for (int i = 0; i < DEPTH; i++) wr(i, $urandom, '1, 1);
      q = {};
      for (int i = 0; i < DEPTH; i++) q.push_back(~m_exp[i]);
      run(DEPTH, q);
      chk("sat_err", err_cnt, SAT);

      // Randomized runs, including counts above DEPTH.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < DEPTH; i++) wr(i, $urandom, $urandom | 32'h1, 1);
         n = $urandom_range(1, DEPTH + 4);
         q = {};
         for (int i = 0; i < DEPTH; i++)
            q.push_back(($urandom_range(0, 3) == 0) ? m_exp[i] ^ $urandom : m_exp[i]);
         run(n, q);
      end

      // Asynchronous abort mid-run, then restart from FAIL.
      start = 1'b1; num_exp = 4; tick; start = 1'b0;
      Result = ~m_exp[0]; result_valid = 1'b1; tick; result_valid = 1'b0;
      #3 rst = 1'b0;
      #1 chk_all_zero("abort");
      #1 rst = 1'b1;
      tick;
      wr(0, 5, '1, 1); wr(1, 10, '1, 1); wr(2, 15, '1, 1); wr(3, 20, '1, 1);
      q = '{5, 11, 15, 99};
      run(4, q);
      chk("restart_in_fail", pass, 0);
      q = '{5, 10, 15, 20};
      run(4, q);
      chk("restart_pass", pass, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
